rv32_timer: RTL and testbench



---
 rtl/rv32_timer.sv | 81 ++++++++
 tb/tb_rv32_timer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_timer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp on a single-cycle data bus,
// with a prescaled mtime tick and a registered level timer interrupt.
module rv32_timer #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel_in,
  input  logic        read_in,
  input  logic        write_in,
  input  logic [31:0] address_in,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic [31:0] read_value_out,
  output logic        interrupt_out
);
  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic [15:0] r_pre;
  logic        r_irq;

  logic        w_rd;
  logic        w_wr;
  logic        w_tick;
  logic [1:0]  w_word;
  logic [31:0] w_cur;
  logic [31:0] w_merged;
  logic        w_unused;

  assign w_rd   = sel_in & read_in;
  assign w_wr   = sel_in & write_in & (|write_mask_in);
  assign w_word = address_in[3:2];
  assign w_tick = (r_pre == PRE_MAX);

  // Only the word select is decoded; the decoder owns the rest of the address.
  assign w_unused = ^{address_in[31:4], address_in[1:0]};

  always_comb begin
    w_cur = 32'h0;
    case (w_word)
      2'd0:    w_cur = r_mtime[31:0];
      2'd1:    w_cur = r_mtime[63:32];
      2'd2:    w_cur = r_mtimecmp[31:0];
      default: w_cur = r_mtimecmp[63:32];
    endcase
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign w_merged[8*g +: 8] = write_mask_in[g] ? write_value_in[8*g +: 8]
                                                 : w_cur[8*g +: 8];
  end

  assign read_value_out = w_rd ? w_cur : 32'h0;
  assign interrupt_out  = r_irq;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mtime    <= 64'h0;
      r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_pre      <= 16'h0;
      r_irq      <= 1'b0;
    end else begin
      r_pre <= w_tick ? 16'h0 : r_pre + 16'h1;
      // Compare uses start-of-cycle values, so a cmp write shows up one edge later.
      r_irq <= (r_mtime >= r_mtimecmp);
      // A bus write to either mtime half swallows a coincident tick.
      if (w_wr && w_word == 2'd0)
        r_mtime[31:0] <= w_merged;
      else if (w_wr && w_word == 2'd1)
        r_mtime[63:32] <= w_merged;
      else if (w_tick)
        r_mtime <= r_mtime + 64'h1;
      if (w_wr && w_word == 2'd2)
        r_mtimecmp[31:0] <= w_merged;
      if (w_wr && w_word == 2'd3)
        r_mtimecmp[63:32] <= w_merged;
    end
  end
endmodule

// File: tb/tb_rv32_timer.sv
// Bench for rv32_timer: a PRESCALE=1 and a PRESCALE=4 instance on a shared bus,
// read expectations queued at drive time and checked when the data settles.
module tb_rv32_timer;
  typedef struct {
    string       nm;
    logic [31:0] exp;
    bit          d4;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        sel1, sel4, read_s, write_s;
  logic [31:0] addr;
  logic [3:0]  mask;
  logic [31:0] wdata;
  logic [31:0] rv1, rv4;
  logic        irq1, irq4;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] got;
  int          checks, fails;
  int          cyc_n;
  bit          mon_en, irq_seen;

  rv32_timer #(.PRESCALE(1)) dut1 (
    .clk(clk), .reset(reset), .sel_in(sel1), .read_in(read_s), .write_in(write_s),
    .address_in(addr), .write_mask_in(mask), .write_value_in(wdata),
    .read_value_out(rv1), .interrupt_out(irq1));

  rv32_timer #(.PRESCALE(4)) dut4 (
    .clk(clk), .reset(reset), .sel_in(sel4), .read_in(read_s), .write_in(write_s),
    .address_in(addr), .write_mask_in(mask), .write_value_in(wdata),
    .read_value_out(rv4), .interrupt_out(irq4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index since reset release: cycle k (1-based) sees cyc_n == k-1.
  always @(posedge clk) cyc_n <= reset ? 0 : cyc_n + 1;

  always @(negedge clk) if (mon_en && (irq1 || irq4)) irq_seen <= 1'b1;

  task automatic drive(input bit s1, input bit s4, input bit r, input bit w,
                       input logic [1:0] wd, input logic [3:0] m, input logic [31:0] d);
    @(negedge clk);
    sel1 = s1; sel4 = s4; read_s = r; write_s = w;
    addr = {28'h0, wd, 2'b00}; mask = m; wdata = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 2'd0, 4'h0, 32'h0);
  endtask

  task automatic wr(input bit d4, input logic [1:0] wd, input logic [3:0] m, input logic [31:0] d);
    drive(!d4, d4, 0, 1, wd, m, d);
  endtask

  task automatic rd(input bit d4, input logic [1:0] wd, input logic [31:0] x, input string nm);
    sb.push_back('{nm: nm, exp: x, d4: d4});
    drive(!d4, d4, 1, 0, wd, 4'h0, 32'h0);
    #1;
  endtask

  task automatic test_reset();
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    rd(0, 2'd0, 32'h0, "rst_mtime_lo");
    e = sb.pop_front(); got = e.d4 ? rv4 : rv1; checks++;
    if (got !== e.exp) begin fails++; $display("FAIL %s: got %h expected %h", e.nm, got, e.exp); end
    rd(0, 2'd2, 32'hFFFF_FFFF, "rst_cmp_lo");
    e = sb.pop_front(); got = e.d4 ? rv4 : rv1; checks++;
    if (got !== e.exp) begin fails++; $display("FAIL %s: got %h expected %h", e.nm, got, e.exp); end
    rd(0, 2'd3, 32'hFFFF_FFFF, "rst_cmp_hi");
    e = sb.pop_front(); got = e.d4 ? rv4 : rv1; checks++;
    if (got !== e.exp) begin fails++; $display("FAIL %s: got %h expected %h", e.nm, got, e.exp); end
    rd(1, 2'd0, 32'h0, "rst4_mtime_lo");
    e = sb.pop_front(); got = e.d4 ? rv4 : rv1; checks++;
    if (got !== e.exp) begin fails++; $display("FAIL %s: got %h expected %h", e.nm, got, e.exp); end
    idle(6);
    rd(0, 2'd0, 32'd10, "run10_lo");
    e = sb.pop_front(); got = e.d4 ? rv4 : rv1; checks++;
    if (got !== e.exp) begin fails++; $display("FAIL %s: got %h expected %h", e.nm, got, e.exp); end
    rd(0, 2'd1, 32'd0, "run10_hi");
    e = sb.pop_front(); got = e.d4 ? rv4 : rv1; checks++;
    if (got !== e.exp) begin fails++; $display("FAIL %s: got %h expected %h", e.nm, got, e.exp); end
    // PRESCALE=4 ticks at the ends of cycles 4, 8 and 12.
    rd(1, 2'd0, 32'd3, "pre4_ticks");
    e = sb.pop_front(); got = e.d4 ? rv4 : rv1; checks++;
    if (got !== e.exp) begin fails++; $display("FAIL %s: got %h expected %h", e.nm, got, e.exp); end
    mon_en = 1'b0;
    @(negedge clk);
    checks++;
    if (irq_seen !== 1'b0) begin fails++; $display("FAIL rst_irq_quiet: got %b expected 0", irq_seen); end
  endtask

  task automatic test_carry_wrap();
    wr(0, 2'd0, 4'hF, 32'hFFFF_FFFF);
    idle(1);
    rd(0, 2'd0, 32'h0, "carry_lo");
    e = sb.pop_front(); got = e.d4 ? rv4 : rv1; checks++;
    if (got !== e.exp) begin fails++; $display("FAIL %s: got %h expected %h", e.nm, got, e.exp); end
    rd(0, 2'd1, 32'h1, "carry_hi");
    e = sb.pop_front(); got = e.d4 ? rv4 : rv1; checks++;
    if (got !== e.exp) begin fails++; $display("FAIL %s: got %h expected %h", e.nm, got, e.exp); end
    wr(0, 2'd1, 4'hF, 32'hFFFF_FFFF);
    wr(0, 2'd0, 4'hF, 32'hFFFF_FFFF);
    rd(0, 2'd0, 32'hFFFF_FFFF, "wrap_ones_lo");
    e = sb.pop_front(); got = e.d4 ? rv4 : rv1; checks++;
    if (got !== e.exp) begin fails++; $display("FAIL %s: got %h expected %h", e.nm, got, e.exp); end
    rd(0, 2'd0, 32'h0, "wrap_lo");
    e = sb.pop_front(); got = e.d4 ? rv4 : rv1; checks++;
    if (got !== e.exp) begin fails++; $display("FAIL %s: got %h expected %h", e.nm, got, e.exp); end
    // All-ones mtime met the all-ones mtimecmp for one cycle.
    checks++;
    if (irq1 !== 1'b1) begin fails++; $display("FAIL wrap_irq_pulse: got %b expected 1", irq1); end
    rd(0, 2'd1, 32'h0, "wrap_hi");
    e = sb.pop_front(); got = e.d4 ? rv4 : rv1; checks++;
    if (got !== e.exp) begin fails++; $display("FAIL %s: got %h expected %h", e.nm, got, e.exp); end
    checks++;
    if (irq1 !== 1'b0) begin fails++; $display("FAIL wrap_irq_drop: got %b expected 0", irq1); end
  endtask

  task automatic test_byte_mask();
    wr(0, 2'd2, 4'b0101, 32'hAABB_CCDD);
    rd(0, 2'd2, 32'hFFBB_FFDD, "mask_cmp_lo");
    e = sb.pop_front(); got = e.d4 ? rv4 : rv1; checks++;
    if (got !== e.exp) begin fails++; $display("FAIL %s: got %h expected %h", e.nm, got, e.exp); end
    rd(0, 2'd3, 32'hFFFF_FFFF, "mask_cmp_hi");
    e = sb.pop_front(); got = e.d4 ? rv4 : rv1; checks++;
    if (got !== e.exp) begin fails++; $display("FAIL %s: got %h expected %h", e.nm, got, e.exp); end
  endtask

  task automatic test_irq();
    int          first;
    logic [31:0] prev_v, hit_v;
    wr(0, 2'd1, 4'hF, 32'h0);
    wr(0, 2'd0, 4'hF, 32'h0);
    wr(0, 2'd3, 4'hF, 32'h0);
    wr(0, 2'd2, 4'hF, 32'd20);
    // mtime is 2 in the first polled cycle and reaches 20 at poll 18.
    first = -1; prev_v = 32'h0; hit_v = 32'h0;
    for (int k = 0; k < 40 && first < 0; k++) begin
      drive(1, 0, 1, 0, 2'd0, 4'h0, 32'h0);
      #1;
      if (irq1 === 1'b1) begin first = k; hit_v = rv1; end
      else prev_v = rv1;
    end
    checks++;
    if (first != 19) begin fails++; $display("FAIL irq_rise_cycle: got %0d expected 19", first); end
    checks++;
    if (hit_v !== 32'd21 || prev_v !== 32'd20) begin
      fails++; $display("FAIL irq_rise_mtime: got %0d/%0d expected 20/21", prev_v, hit_v);
    end
    wr(0, 2'd3, 4'hF, 32'h1);
    rd(0, 2'd3, 32'h1, "irq_clr_cmp_hi");
    e = sb.pop_front(); got = e.d4 ? rv4 : rv1; checks++;
    if (got !== e.exp) begin fails++; $display("FAIL %s: got %h expected %h", e.nm, got, e.exp); end
    checks++;
    if (irq1 !== 1'b1) begin fails++; $display("FAIL irq_clr_hold: got %b expected 1", irq1); end
    rd(0, 2'd2, 32'd20, "irq_clr_cmp_lo");
    e = sb.pop_front(); got = e.d4 ? rv4 : rv1; checks++;
    if (got !== e.exp) begin fails++; $display("FAIL %s: got %h expected %h", e.nm, got, e.exp); end
    checks++;
    if (irq1 !== 1'b0) begin fails++; $display("FAIL irq_clr_fall: got %b expected 0", irq1); end
  endtask

  task automatic test_collision();
    logic [31:0] exp_v[5] = '{32'd100, 32'd100, 32'd100, 32'd100, 32'd101};
    do idle(1); while ((cyc_n + 1) % 4 != 0);
    sel4 = 1'b1; write_s = 1'b1; addr = 32'h0; mask = 4'hF; wdata = 32'd100;
    for (int i = 0; i < 5; i++) begin
      rd(1, 2'd0, exp_v[i], $sformatf("collide_t%0d", i + 1));
      e = sb.pop_front(); got = e.d4 ? rv4 : rv1; checks++;
      if (got !== e.exp) begin fails++; $display("FAIL %s: got %h expected %h", e.nm, got, e.exp); end
    end
  endtask

  task automatic test_unselected();
    drive(0, 0, 1, 1, 2'd2, 4'hF, 32'h0);
    #1;
    checks++;
    if (rv1 !== 32'h0 || rv4 !== 32'h0) begin
      fails++; $display("FAIL unsel_rdata: got %h/%h expected 0/0", rv1, rv4);
    end
    rd(0, 2'd2, 32'd20, "unsel_keep_lo");
    e = sb.pop_front(); got = e.d4 ? rv4 : rv1; checks++;
    if (got !== e.exp) begin fails++; $display("FAIL %s: got %h expected %h", e.nm, got, e.exp); end
    drive(1, 0, 0, 1, 2'd3, 4'h0, 32'h0);
    #1;
    checks++;
    if (rv1 !== 32'h0) begin fails++; $display("FAIL noread_rdata: got %h expected 0", rv1); end
    rd(0, 2'd3, 32'h1, "mask0_keep_hi");
    e = sb.pop_front(); got = e.d4 ? rv4 : rv1; checks++;
    if (got !== e.exp) begin fails++; $display("FAIL %s: got %h expected %h", e.nm, got, e.exp); end
  endtask

  task automatic test_reset_midcount();
    do idle(1); while ((cyc_n + 1) % 4 != 2);
    // Reset lands on a non-zero prescaler phase and beats a concurrent write.
    reset = 1'b1; sel4 = 1'b1; write_s = 1'b1; addr = 32'h8; mask = 4'hF; wdata = 32'h0;
    @(posedge clk);
    #1 reset = 1'b0;
    rd(1, 2'd2, 32'hFFFF_FFFF, "midrst_over_wr");
    e = sb.pop_front(); got = e.d4 ? rv4 : rv1; checks++;
    if (got !== e.exp) begin fails++; $display("FAIL %s: got %h expected %h", e.nm, got, e.exp); end
    rd(0, 2'd3, 32'hFFFF_FFFF, "midrst_cmp1_hi");
    e = sb.pop_front(); got = e.d4 ? rv4 : rv1; checks++;
    if (got !== e.exp) begin fails++; $display("FAIL %s: got %h expected %h", e.nm, got, e.exp); end
    idle(1);
    rd(1, 2'd0, 32'd0, "midrst_pre_c4");
    e = sb.pop_front(); got = e.d4 ? rv4 : rv1; checks++;
    if (got !== e.exp) begin fails++; $display("FAIL %s: got %h expected %h", e.nm, got, e.exp); end
    rd(1, 2'd0, 32'd1, "midrst_tick_c5");
    e = sb.pop_front(); got = e.d4 ? rv4 : rv1; checks++;
    if (got !== e.exp) begin fails++; $display("FAIL %s: got %h expected %h", e.nm, got, e.exp); end
  endtask

  initial begin
    checks = 0; fails = 0; mon_en = 1'b0; irq_seen = 1'b0;
    reset = 1'b1; sel1 = 1'b0; sel4 = 1'b0; read_s = 1'b0; write_s = 1'b0;
    addr = 32'h0; mask = 4'h0; wdata = 32'h0;
    test_reset();
    test_carry_wrap();
    test_byte_mask();
    test_irq();
    test_collision();
    test_unselected();
    test_reset_midcount();
    idle(1);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
